// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port RAM with registered synchronous read
module sync_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (i_re) begin
      rdata_d = mem[i_raddr];
    end
  end

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  output logic                       o_empty,
  output logic                       o_full,
  input  logic                       i_write,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_read,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_queued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;

  assign o_empty  = (count_q == '0);
  assign o_full   = (count_q == FULL_CNT);
  assign o_queued = count_q;

  // A write at full is dropped even when a pop frees a slot this cycle.
  assign push = i_write && !o_full;
  assign pop  = i_read && !o_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (push),
    .i_waddr (wptr_q),
    .i_wdata (i_wdata),
    .i_re    (pop),
    .i_raddr (rptr_q),
    .o_rdata (o_rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_write = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_wdata = '0;

  logic        e4, f4, e3, f3, e32, f32;
  logic [31:0] rd4, rd3, rd32;
  logic [2:0]  q4;
  logic [1:0]  q3;
  logic [5:0]  q32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(4), .WIDTH(32)) u4 (
    .i_clock(clk), .i_reset(i_reset), .o_empty(e4), .o_full(f4),
    .i_write(i_write), .i_wdata(i_wdata), .i_read(i_read),
    .o_rdata(rd4), .o_queued(q4)
  );

  sync_fifo #(.DEPTH(3), .WIDTH(32)) u3 (
    .i_clock(clk), .i_reset(i_reset), .o_empty(e3), .o_full(f3),
    .i_write(i_write), .i_wdata(i_wdata), .i_read(i_read),
    .o_rdata(rd3), .o_queued(q3)
  );

  sync_fifo #(.DEPTH(32), .WIDTH(32)) u32 (
    .i_clock(clk), .i_reset(i_reset), .o_empty(e32), .o_full(f32),
    .i_write(i_write), .i_wdata(i_wdata), .i_read(i_read),
    .o_rdata(rd32), .o_queued(q32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    i_write = w;
    i_wdata = d;
    i_read  = r;
    @(posedge clk);
    #1;
    i_write = 1'b0;
    i_read  = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    i_reset = 1'b1;
  endtask

  initial begin
    // Reset then idle
    do_reset();
    check("rst_empty", 32'(e4), 32'd1);
    check("rst_full", 32'(f4), 32'd0);
    check("rst_queued", 32'(q4), 32'd0);
    check("rst_rdata", rd4, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check("idle_pop_rdata", rd4, 32'h0);
    check("idle_pop_queued", 32'(q4), 32'd0);

    // Fill DEPTH=4, overflow, drain
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
      check($sformatf("fill_queued%0d", i), 32'(q4), 32'(i + 1));
    end
    check("fill_full", 32'(f4), 32'd1);
    cycle(1'b1, 32'hFF, 1'b0);
    check("ovf_queued", 32'(q4), 32'd4);
    check("ovf_full", 32'(f4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check($sformatf("drain_rdata%0d", i), rd4, 32'hA0 + 32'(i));
    end
    check("drain_empty", 32'(e4), 32'd1);
    check("drain_queued", 32'(q4), 32'd0);

    // Simultaneous push/pop at occupancy 2
    do_reset();
    cycle(1'b1, 32'h11, 1'b0);
    cycle(1'b1, 32'h22, 1'b0);
    cycle(1'b1, 32'h33, 1'b1);
    check("pp_queued", 32'(q4), 32'd2);
    check("pp_rdata", rd4, 32'h11);
    cycle(1'b0, 32'h0, 1'b1);
    check("pp_rdata2", rd4, 32'h22);
    cycle(1'b0, 32'h0, 1'b1);
    check("pp_rdata3", rd4, 32'h33);

    // Continuous push/pop across pointer wrap, DEPTH=3
    do_reset();
    cycle(1'b1, 32'h100, 1'b0);
    cycle(1'b1, 32'h101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h102 + 32'(i), 1'b1);
      check($sformatf("wrap_rdata%0d", i), rd3, 32'h100 + 32'(i));
      check($sformatf("wrap_queued%0d", i), 32'(q3), 32'd2);
    end
    cycle(1'b0, 32'h0, 1'b1);
    check("wrap_tail0", rd3, 32'h10A);
    cycle(1'b0, 32'h0, 1'b1);
    check("wrap_tail1", rd3, 32'h10B);
    check("wrap_empty", 32'(e3), 32'd1);

    // Write+read at empty: no fall-through
    do_reset();
    cycle(1'b1, 32'h77, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("we_pre_rdata", rd4, 32'h77);
    cycle(1'b1, 32'h55, 1'b1);
    check("we_rdata_hold", rd4, 32'h77);
    check("we_queued", 32'(q4), 32'd1);
    cycle(1'b0, 32'h0, 1'b1);
    check("we_pop", rd4, 32'h55);

    // Write+read at full: write dropped, pop accepted
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    cycle(1'b1, 32'hEE, 1'b1);
    check("wf_queued", 32'(q4), 32'd3);
    check("wf_full", 32'(f4), 32'd0);
    check("wf_rdata", rd4, 32'hC0);
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check($sformatf("wf_drain%0d", i), rd4, 32'hC0 + 32'(i));
    end
    check("wf_empty", 32'(e4), 32'd1);

    // Reset with 3 entries queued, DEPTH=32; reset beats concurrent write/read
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("r32_pre_rdata", rd32, 32'hD0);
    check("r32_pre_queued", 32'(q32), 32'd3);
    i_reset = 1'b0;
    cycle(1'b1, 32'hBAD, 1'b1);
    i_reset = 1'b1;
    check("r32_empty", 32'(e32), 32'd1);
    check("r32_queued", 32'(q32), 32'd0);
    check("r32_rdata", rd32, 32'h0);
    check("r32_full", 32'(f32), 32'd0);
    cycle(1'b1, 32'hE1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("r32_new", rd32, 32'hE1);
    check("r32_new_empty", 32'(e32), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO holding up to DEPTH entries of WIDTH bits, with a registered read port. It is the queue primitive behind the write buffer and other bus-side buffering. The same block serves small register-based queues and deep block-RAM queues: storage style follows from DEPTH, and behaviour is identical for both.

## Interface
- DEPTH, default 16: number of entries, any integer ≥ 2 (non-power-of-two allowed).
- WIDTH, default 32: entry width in bits.
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  synchronous, active-low reset.
- o_empty  out  1  high when occupancy is 0.
- o_full  out  1  high when occupancy equals DEPTH.
- i_write  in  1  push i_wdata this cycle; ignored when full.
- i_wdata  in  WIDTH  data to push.
- i_read  in  1  pop head this cycle; ignored when empty.
- o_rdata  out  WIDTH  registered data of the last accepted pop.
- o_queued  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - write pointer, read pointer, each 0..DEPTH-1, wrapping from DEPTH-1 to 0 by explicit compare (not by bit overflow);
  - occupancy counter.
- Push accepted when i_write && !o_full:
  - mem[wptr] <= i_wdata;
  - wptr advances.
- Pop accepted when i_read && !o_empty:
  - o_rdata <= mem[rptr];
  - rptr advances.
- o_rdata holds its value until the next accepted pop; it is not show-ahead.
- Occupancy update: +1 on push only, −1 on pop only, unchanged when both are accepted in the same cycle.
- Flags derived from occupancy:
  - o_empty = (count == 0);
  - o_full = (count == DEPTH);
  - o_queued = count.
- Boundary rules:
  - Write while full: dropped, even if a read is accepted in the same cycle. No data or pointer change from the write.
  - Read while empty: ignored; o_rdata unchanged. A simultaneous write is accepted, but there is no fall-through: the new entry is not visible on o_rdata that cycle.
  - Simultaneous push and pop at occupancy 1..DEPTH-1: both accepted and the count stays the same. The pop returns the old head, never the data being written.
- Reset (i_reset low at a clock edge), which overrides any concurrent read or write:
  - pointers = 0, count = 0;
  - o_empty = 1, o_full = 0, o_queued = 0, o_rdata = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued entries.

## Timing
- Push latency: an entry written at edge N is poppable at edge N+1 (o_empty falls after edge N).
- Pop latency: with i_read high at edge N, o_rdata is valid after edge N and is used by the consumer in cycle N+1.
- Flags and o_queued are registered or derived from registered count only; no combinational path from i_read/i_write to any output.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- No shared package required; no typedefs or constants are exported.
- One sub-module, sync_fifo_ram: simple dual-port RAM with one write port and one synchronous read port on i_clock.
  - Read output register inside the RAM, so block RAM is inferred for DEPTH > 16.
  - Distributed/registers otherwise, with the same registered read.
- Pointer, counter and flag logic stays in sync_fifo.

## Test plan
- Reset then idle:
  - o_empty=1, o_full=0, o_queued=0, o_rdata=0.
  - i_read pulse leaves o_rdata=0 and o_queued=0.
- DEPTH=4, WIDTH=32, fill:
  - Push 0xA0..0xA3: o_queued 1,2,3,4; o_full=1 after the fourth push.
  - Fifth push of 0xFF is dropped.
  - Pop four times: o_rdata 0xA0,0xA1,0xA2,0xA3, each one cycle after its pop; then o_empty=1.
- Simultaneous push/pop at occupancy 2:
  - Count stays 2.
  - The pop returns the oldest entry.
  - The subsequent order is preserved across pointer wrap (push/pop 10 entries continuously, DEPTH=3).
- Write+read at empty:
  - Push 0x55 accepted and o_rdata unchanged.
  - Next-cycle pop yields 0x55.
- Write+read at full:
  - The write is dropped and the pop is accepted.
  - o_queued goes DEPTH→DEPTH-1.
- Reset with 3 entries queued (DEPTH=32, block-RAM build):
  - o_empty=1, o_queued=0, o_rdata=0 after the edge.
  - The next push/pop returns the new data only.
